spi_mem_target: RTL and testbench
=================================

Name: spi_mem_target

Overview:
SPI target (mode 0, MSB first) that gives an external SPI host read/write access to the SoC's word-addressed single-port RAM interface. It is the far end of the SoC's SPI master (sck/sdo/sdi/cs) and drives the same ram_* signalling the core uses. It is used for debug/boot-load over the spare SRAM access path. All SPI inputs are asynchronous to clk_i and are oversampled.

Parameters:
RAM_ADDR_WIDTH, 12, word-address width of the RAM port; upper bits of the 16-bit SPI address are dropped.
SYNC_STAGES, 2, synchroniser depth for spi_sck_i, spi_csn_i and spi_sdi_i (minimum 2).

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
spi_sck_i  input  1  SPI clock from host; fsck <= fclk/8
spi_csn_i  input  1  chip select, active-low
spi_sdi_i  input  1  host-to-target data
spi_sdo_o  output  1  target-to-host data
spi_sdo_oe_o  output  1  sdo output enable; 1 only in read-data/status phases
ram_en_o  output  1  RAM access strobe, 1 cycle per access
ram_we_o  output  1  1 = write, valid with ram_en_o
ram_be_o  output  4  byte enables; always 4'hF on writes, 4'h0 otherwise
ram_addr_o  output  RAM_ADDR_WIDTH  word address
ram_wdata_o  output  32  write data
ram_rdata_i  input  32  read data, valid exactly 1 cycle after ram_en_o && !ram_we_o
busy_o  output  1  1 while csn is (synchronised) low

Behaviour:
- Reset (rst_i sampled high at a clk_i edge): all outputs 0, FSM in IDLE, synchronisers loaded with csn=1, sck=0.
- Inputs pass through SYNC_STAGES flops, plus one extra sck flop for edge detection. "rise"/"fall" mean a detected sck edge. All events below are relative to the detection cycle.
- Frame: csn fall -> CMD. Then 8 command bits, 16 address bits (word address) and N 32-bit data words. Bits are sampled on rise, and sdo changes on fall.
- FSM states: IDLE, CMD, ADDR, RD_DATA, WR_DATA, IGNORE (plus STATUS with the optional feature).
  - CMD: after 8 bits, 0x03 -> ADDR (read), 0x02 -> ADDR (write), anything else -> IGNORE.
  - ADDR: after 16 bits, latch addr[RAM_ADDR_WIDTH-1:0].
    - Read: issue ram_en_o (we=0) on the cycle after the 16th rise, load the shift register from ram_rdata_i on the following cycle, then go to RD_DATA.
    - Write: go to WR_DATA.
  - RD_DATA:
    - sdo_oe=1. Bit 31 is driven on the first fall and each later fall shifts.
    - On the rise that samples bit 0 of a word, prefetch addr+1 into a holding buffer (ram_en_o pulse, capture 1 cycle later). The next fall loads the buffer into the shift register, driving the new bit 31.
  - WR_DATA: after each 32nd rise, ram_en_o=ram_we_o=1, ram_be_o=4'hF, ram_wdata_o=word, ram_addr_o=addr for exactly one cycle, then increment addr.
  - IGNORE: sdo_oe=0 until csn high.
- Address increments modulo 2^RAM_ADDR_WIDTH (wraps max -> 0).
- csn high in any state -> IDLE in the same detection cycle; sdo_oe=0 and sdo=0 next cycle. A partial write word is discarded. A prefetch already issued completes its capture, but its data is never shifted out.
- csn rise coinciding with a rise: that sck edge is ignored.
- Outside a memory access, ram_en_o=0 and ram_we_o=0. ram_addr_o and ram_wdata_o hold their last values.
- Reset mid-frame: immediate IDLE. The frame resumes only after a fresh csn fall.

Optional Feature:
SPI_MEM_TARGET_STATUS_EN
- Defined: command 0x05 -> STATUS. It returns 0xA5 followed by an 8-bit count of completed RAM word writes (wraps at 255->0, cleared by rst_i), then repeats the count until csn high. No RAM access occurs.
- Undefined: 0x05 is an unknown command -> IGNORE. There is no write counter.

Test Plan:
- Write: cmd 0x02, addr 0x0010, data 0xDEADBEEF, 0x01234567 -> two ram_en_o/ram_we_o pulses, be=4'hF, at addr 0x010 (0xDEADBEEF) and 0x011 (0x01234567).
- Read: RAM model holds 0x010=0xDEADBEEF, 0x011=0x01234567. Cmd 0x03, addr 0x0010, 64 clocks -> host receives 0xDEADBEEF then 0x01234567. Exactly two reads before the second word starts, plus one prefetch of 0x012.
- Wrap: write at addr 0x0FFF of two words -> writes hit 0xFFF then 0x000. Addr 0xF005 maps to 0x005.
- Abort: cmd 0x02, addr 0, 20 data bits, then csn high -> no ram_en_o. A new read frame still works.
- Unknown cmd 0x9F with 32 further clocks -> no ram_en_o, spi_sdo_oe_o=0 throughout.
- (STATUS_EN) After 3 word writes, cmd 0x05 -> host reads 0xA5, 0x03. rst_i then cmd 0x05 -> 0xA5, 0x00.

Source files
------------

// File: rtl/spi_mem_target_if.sv
// spi_mem_target_if: word-addressed single-port RAM bus driven by the SPI memory target
interface spi_mem_target_if #(parameter int AW = 12);
  logic          en;
  logic          we;
  logic [3:0]    be;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  modport master (output en, we, be, addr, wdata, input rdata);
  modport slave  (input en, we, be, addr, wdata, output rdata);
endinterface

// File: rtl/spi_mem_target.sv
// spi_mem_target: SPI mode-0 target giving a host read/write access to a word RAM.
// Define SPI_MEM_TARGET_STATUS_EN to add command 0x05 (0xA5 + completed-write count).
module spi_mem_target #(
  parameter int RAM_ADDR_WIDTH = 12,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                spi_sck_i,
  input  logic                spi_csn_i,
  input  logic                spi_sdi_i,
  output logic                spi_sdo_o,
  output logic                spi_sdo_oe_o,
  output logic                busy_o,
  spi_mem_target_if.master    ram
);
  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, RD_DATA, WR_DATA, IGNORE
`ifdef SPI_MEM_TARGET_STATUS_EN
    , STATUS
`endif
  } state_t;
  state_t                    state_q;
  logic [SYNC_STAGES-1:0]    sck_q, csn_q, sdi_q, arm_q;
  logic                      sck_prev_q, csn_prev_q, first_q, rd_q, rv_q;
  logic                      en_q, we_q, sdo_q, oe_q, busy_q;
  logic [3:0]                be_q;
  logic [4:0]                cnt_q;
  logic [30:0]               sr_q;
  logic [31:0]               tx_q, buf_q, wdata_q;
  logic [RAM_ADDR_WIDTH-1:0] addr_q, ram_addr_q;
  logic                      sck_s, csn_s, sdi_s, rise, fall, csn_fall;
  logic [31:0]               rx_d, ld_d;
`ifdef SPI_MEM_TARGET_STATUS_EN
  logic [7:0]                wcnt_q;
  assign ld_d = (state_q == STATUS) ? {wcnt_q, 24'h0} : buf_q;
`else
  assign ld_d = buf_q;
`endif
  assign sck_s    = sck_q[SYNC_STAGES-1];
  assign csn_s    = csn_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_q[SYNC_STAGES-1];
  assign rise     = sck_s & ~sck_prev_q;
  assign fall     = ~sck_s & sck_prev_q;
  assign csn_fall = csn_prev_q & ~csn_s;
  assign rx_d     = {sr_q, sdi_s};
  assign spi_sdo_o    = sdo_q;
  assign spi_sdo_oe_o = oe_q;
  assign busy_o       = busy_q;
  assign ram.en       = en_q;
  assign ram.we       = we_q;
  assign ram.be       = be_q;
  assign ram.addr     = ram_addr_q;
  assign ram.wdata    = wdata_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_q      <= '0;
      csn_q      <= '1;
      sdi_q      <= '0;
      arm_q      <= '0;
      sck_prev_q <= 1'b0;
      csn_prev_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      tx_q       <= '0;
      buf_q      <= '0;
      addr_q     <= '0;
      ram_addr_q <= '0;
      wdata_q    <= '0;
      first_q    <= 1'b0;
      rd_q       <= 1'b0;
      rv_q       <= 1'b0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      sdo_q      <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SPI_MEM_TARGET_STATUS_EN
      wcnt_q     <= '0;
`endif
    end else begin
      sck_q      <= {sck_q[SYNC_STAGES-2:0], spi_sck_i};
      csn_q      <= {csn_q[SYNC_STAGES-2:0], spi_csn_i};
      sdi_q      <= {sdi_q[SYNC_STAGES-2:0], spi_sdi_i};
      arm_q      <= {arm_q[SYNC_STAGES-2:0], 1'b1};
      sck_prev_q <= sck_s;
      // csn only counts as high once the chain holds real samples, so a frame never resumes after reset
      csn_prev_q <= csn_s & arm_q[SYNC_STAGES-1];
      busy_q     <= ~csn_s;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      rv_q       <= en_q & ~we_q;
      if (rv_q) buf_q <= ram.rdata;
      if (state_q != IDLE && csn_s) begin
        state_q <= IDLE;
        oe_q    <= 1'b0;
        sdo_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (csn_fall) begin
            state_q <= CMD;
            cnt_q   <= '0;
          end
          CMD: if (rise) begin
            sr_q  <= rx_d[30:0];
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_q   <= '0;
              state_q <= (rx_d[7:1] == 7'h01) ? ADDR : IGNORE;
              rd_q    <= rx_d[0];
`ifdef SPI_MEM_TARGET_STATUS_EN
              if (rx_d[7:0] == 8'h05) begin
                state_q <= STATUS;
                tx_q    <= {8'hA5, 24'h0};
                first_q <= 1'b1;
                oe_q    <= 1'b1;
              end
`endif
            end
          end
          ADDR: if (rv_q) begin
            tx_q    <= ram.rdata;
            first_q <= 1'b1;
            oe_q    <= 1'b1;
            state_q <= RD_DATA;
          end else if (rise) begin
            sr_q  <= rx_d[30:0];
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
              cnt_q      <= '0;
              addr_q     <= rx_d[RAM_ADDR_WIDTH-1:0];
              ram_addr_q <= rx_d[RAM_ADDR_WIDTH-1:0];
              en_q       <= rd_q;
              if (!rd_q) state_q <= WR_DATA;
            end
          end
          WR_DATA: if (rise) begin
            sr_q  <= rx_d[30:0];
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              en_q       <= 1'b1;
              we_q       <= 1'b1;
              be_q       <= 4'hF;
              wdata_q    <= rx_d;
              ram_addr_q <= addr_q;
              addr_q     <= addr_q + RAM_ADDR_WIDTH'(1);
`ifdef SPI_MEM_TARGET_STATUS_EN
              wcnt_q     <= wcnt_q + 8'd1;
`endif
            end
          end
          IGNORE: ;
          default: begin
            if (rise) begin
`ifdef SPI_MEM_TARGET_STATUS_EN
              cnt_q <= (state_q == STATUS && cnt_q == 5'd7) ? 5'd0 : cnt_q + 5'd1;
`else
              cnt_q <= cnt_q + 5'd1;
`endif
              // bit 0 of a word just sampled: fetch the next word into the holding buffer
              if (state_q == RD_DATA && cnt_q == 5'd31) begin
                en_q       <= 1'b1;
                addr_q     <= addr_q + RAM_ADDR_WIDTH'(1);
                ram_addr_q <= addr_q + RAM_ADDR_WIDTH'(1);
              end
            end
            if (fall) begin
              first_q <= 1'b0;
              if (first_q) sdo_q <= tx_q[31];
              else if (cnt_q == 5'd0) begin
                tx_q  <= ld_d;
                sdo_q <= ld_d[31];
              end else begin
                tx_q  <= {tx_q[30:0], 1'b0};
                sdo_q <= tx_q[30];
              end
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_mem_target.sv
// tb_spi_mem_target: directed SPI host frames against a RAM model with a bus access log.
module tb_spi_mem_target;
  logic clk = 1'b0, rst = 1'b1, sck = 1'b0, csn = 1'b1, sdi = 1'b0;
  logic sdo, sdo_oe, busy;
  int   n_cmp = 0, n_bad = 0;
  int   nacc = 0, oe_cnt = 0;
  logic [31:0] la [256];
  logic [31:0] ld [256];
  logic        lw [256];
  logic [3:0]  lb [256];
  logic [31:0] mem [4096];
  logic [127:0] q;
  int a0, o0;

  spi_mem_target_if #(.AW(12)) ram_if ();

  spi_mem_target #(.RAM_ADDR_WIDTH(12), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .spi_sck_i(sck), .spi_csn_i(csn), .spi_sdi_i(sdi),
    .spi_sdo_o(sdo), .spi_sdo_oe_o(sdo_oe), .busy_o(busy), .ram(ram_if.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_if.en && ram_if.we) mem[ram_if.addr] <= ram_if.wdata;
    if (ram_if.en && !ram_if.we) ram_if.rdata <= mem[ram_if.addr];
    if (ram_if.en) begin
      la[nacc[7:0]] <= {20'h0, ram_if.addr};
      ld[nacc[7:0]] <= ram_if.wdata;
      lw[nacc[7:0]] <= ram_if.we;
      lb[nacc[7:0]] <= ram_if.be;
      nacc <= nacc + 1;
    end
    if (sdo_oe) oe_cnt <= oe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic r);
    sdi = b;
    #40 sck = 1'b1;
    r = sdo;
    #40 sck = 1'b0;
  endtask

  task automatic frame(input logic [7:0] c, input logic [15:0] a, input int n,
                       input logic [127:0] d, output logic [127:0] rx);
    logic r;
    rx = '0;
    csn = 1'b0;
    #80 chk("busy_in_frame", busy, 1'b1);
    for (int i = 7; i >= 0; i--) spi_bit(c[i], r);
    for (int i = 15; i >= 0; i--) spi_bit(a[i], r);
    for (int i = 0; i < n; i++) begin
      spi_bit(d[127-i], r);
      rx = {rx[126:0], r};
    end
    #80 csn = 1'b1;
    sdi = 1'b0;
    #200;
    chk("idle_after_frame", {busy, sdo_oe, sdo}, 3'b000);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    #32 rst = 1'b0;
    #20;
    chk("rst_outs", {sdo, sdo_oe, busy, ram_if.en, ram_if.we, ram_if.be}, 9'h0);
    chk("rst_bus", {ram_if.addr, ram_if.wdata}, 44'h0);

    a0 = nacc;
    frame(8'h02, 16'h0010, 64, {64'hDEADBEEF_01234567, 64'h0}, q);
    chk("wr_count", nacc - a0, 2);
    chk("wr0", {la[a0], ld[a0], lw[a0], lb[a0]}, {32'h010, 32'hDEADBEEF, 1'b1, 4'hF});
    chk("wr1", {la[a0+1], ld[a0+1], lw[a0+1], lb[a0+1]}, {32'h011, 32'h01234567, 1'b1, 4'hF});

    a0 = nacc; o0 = oe_cnt;
    frame(8'h03, 16'h0010, 64, '0, q);
    chk("rd_data", q[63:0], 64'hDEADBEEF_01234567);
    chk("rd_count", nacc - a0, 3);
    chk("rd_addrs", {la[a0], la[a0+1], la[a0+2]}, {32'h010, 32'h011, 32'h012});
    chk("rd_we_be", {lw[a0], lb[a0], lw[a0+2], lb[a0+2]}, 10'h0);
    chk("rd_oe", oe_cnt > o0, 1'b1);

    a0 = nacc;
    frame(8'h02, 16'h0FFF, 64, {64'h11111111_22222222, 64'h0}, q);
    chk("wrap_addrs", {nacc - a0, la[a0], la[a0+1]}, {32'd2, 32'hFFF, 32'h000});
    chk("wrap_data", {ld[a0], ld[a0+1]}, 64'h11111111_22222222);
    a0 = nacc;
    frame(8'h02, 16'hF005, 32, {32'hCAFEF00D, 96'h0}, q);
    chk("hi_addr_drop", {nacc - a0, la[a0], ld[a0]}, {32'd1, 32'h005, 32'hCAFEF00D});
    frame(8'h03, 16'hF005, 32, '0, q);
    chk("hi_addr_read", q[31:0], 32'hCAFEF00D);

    a0 = nacc;
    frame(8'h02, 16'h0000, 20, {20'hABCDE, 108'h0}, q);
    chk("abort_no_access", nacc - a0, 0);
    chk("abort_mem0", mem[0], 32'h22222222);
    frame(8'h03, 16'h0010, 32, '0, q);
    chk("read_after_abort", q[31:0], 32'hDEADBEEF);

    a0 = nacc; o0 = oe_cnt;
    frame(8'h9F, 16'hFFFF, 16, '1, q);
    chk("unk_no_access", nacc - a0, 0);
    chk("unk_no_oe", {oe_cnt - o0, q[15:0]}, 48'h0);

    begin
      logic r;
      a0 = nacc; o0 = oe_cnt;
      csn = 1'b0;
      #80;
      for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
      rst = 1'b1;
      #20 rst = 1'b0;
      for (int i = 0; i < 56; i++) spi_bit((i == 6), r);
      chk("rst_mid_no_access", {nacc - a0, oe_cnt - o0}, 64'h0);
      #80 csn = 1'b1;
      #200;
    end
    frame(8'h03, 16'h0011, 32, '0, q);
    chk("read_after_rst", q[31:0], 32'h01234567);

`ifdef SPI_MEM_TARGET_STATUS_EN
    frame(8'h02, 16'h0100, 96, {96'h00000001_00000002_00000003, 32'h0}, q);
    a0 = nacc;
    frame(8'h05, 16'h0000, 8, '0, q);
    chk("status_3", {q[7:0], nacc - a0}, {8'h03, 32'd0});
    begin
      logic [127:0] s;
      csn = 1'b0;
      #80;
      for (int i = 0; i < 24; i++) begin
        logic r;
        spi_bit(i < 8 ? ((8'h05 >> (7 - i)) & 8'h1) != 0 : 1'b0, r);
        if (i >= 8) s = {s[126:0], r};
      end
      for (int i = 0; i < 8; i++) begin
        logic r;
        spi_bit(1'b0, r);
        s = {s[126:0], r};
      end
      chk("status_seq", s[23:0], 24'hA50303);
      #80 csn = 1'b1;
      #200;
    end
    rst = 1'b1;
    #20 rst = 1'b0;
    #40;
    begin
      logic r;
      logic [15:0] s;
      csn = 1'b0;
      #80;
      for (int i = 7; i >= 0; i--) spi_bit(((8'h05 >> i) & 8'h1) != 0, r);
      for (int i = 0; i < 16; i++) begin
        spi_bit(1'b0, r);
        s = {s[14:0], r};
      end
      chk("status_after_rst", s, 16'hA500);
      #80 csn = 1'b1;
      #200;
    end
`else
    a0 = nacc; o0 = oe_cnt;
    frame(8'h05, 16'h0000, 16, '0, q);
    chk("cmd05_ignored", {nacc - a0, oe_cnt - o0, q[15:0]}, 80'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
